vga_timing_gen: RTL



---
 rtl/vga_timing_gen.sv | 115 +++++++++++
 1 files changed

// File: rtl/vga_timing_gen.sv
// vga_timing_gen
// Free-running VGA raster timing generator (640x480@60 Hz by default).
// Produces pixel/line counters, active-high sync pulses, visible-area flag,
// end-of-line / end-of-frame markers and a wrapping completed-frame counter.
// Every output is a flop output, so sync pins and strobes are glitch-free.
//
// Ports:
//   clk      in   1   pixel clock, all state on rising edge
//   reset_n  in   1   asynchronous active-low reset
//   ena      in   1   count enable; when low, all state holds
//   hsync    out  1   active-high horizontal sync
//   vsync    out  1   active-high vertical sync
//   hpos     out  10  current pixel column, 0..H_TOTAL-1
//   vpos     out  10  current line, 0..V_TOTAL-1
//   hmax     out  1   high while hpos == H_TOTAL-1
//   vmax     out  1   high while vpos == V_TOTAL-1
//   visible  out  1   high while hpos < H_VIS and vpos < V_VIS
//   frame    out  8   completed-frame count, wraps mod 256
module vga_timing_gen #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ena,
    output logic       hsync,
    output logic       vsync,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       hmax,
    output logic       vmax,
    output logic       visible,
    output logic [7:0] frame
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    // Both totals must be representable by the 10-bit position counters.
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must fit in 10 bits");
    end

    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    // Region bounds held in 11 bits so an end bound of exactly 1024 still compares correctly.
    localparam logic [10:0] H_VIS_END = 11'(H_VIS);
    localparam logic [10:0] HS_START  = 11'(H_VIS + H_FP);
    localparam logic [10:0] HS_END    = 11'(H_VIS + H_FP + H_SYNC);
    localparam logic [10:0] V_VIS_END = 11'(V_VIS);
    localparam logic [10:0] VS_START  = 11'(V_VIS + V_FP);
    localparam logic [10:0] VS_END    = 11'(V_VIS + V_FP + V_SYNC);

    logic [9:0]  h_next;
    logic [9:0]  v_next;
    logic [7:0]  frame_next;
    logic [10:0] h_ext;
    logic [10:0] v_ext;

    // Next-state counters. With ena low the next state equals the current
    // state, so the flags below stay consistent with the frozen position.
    always_comb begin
        h_next     = hpos;
        v_next     = vpos;
        frame_next = frame;
        if (ena) begin
            if (hpos == H_LAST) begin
                h_next = '0;
                if (vpos == V_LAST) begin
                    v_next     = '0;
                    frame_next = frame + 8'd1;
                end else begin
                    v_next = vpos + 10'd1;
                end
            end else begin
                h_next = hpos + 10'd1;
            end
        end
    end

    assign h_ext = {1'b0, h_next};
    assign v_ext = {1'b0, v_next};

    // Flags are decoded from the next-state position and registered, so they
    // line up with hpos/vpos in the same cycle (zero relative skew).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hpos    <= '0;
            vpos    <= '0;
            frame   <= '0;
            hsync   <= 1'b0;
            vsync   <= 1'b0;
            hmax    <= 1'b0;
            vmax    <= 1'b0;
            visible <= 1'b1;
        end else begin
            hpos    <= h_next;
            vpos    <= v_next;
            frame   <= frame_next;
            hsync   <= (h_ext >= HS_START) && (h_ext < HS_END);
            vsync   <= (v_ext >= VS_START) && (v_ext < VS_END);
            hmax    <= (h_next == H_LAST);
            vmax    <= (v_next == V_LAST);
            visible <= (h_ext < H_VIS_END) && (v_ext < V_VIS_END);
        end
    end

endmodule
